// File: rtl/cpu_pkg.sv
// Shared definitions for the 6502 status register: flag bit positions,
// flag-instruction encodings, and the reset image of P.
package cpu_pkg;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_I = 2;
  localparam int FLAG_D = 3;
  localparam int FLAG_B = 4;
  localparam int FLAG_U = 5;
  localparam int FLAG_V = 6;
  localparam int FLAG_N = 7;

  localparam logic [7:0] P_RESET = 8'h24;

  typedef enum logic [2:0] {
    OP_CLC = 3'd0,
    OP_SEC = 3'd1,
    OP_CLI = 3'd2,
    OP_SEI = 3'd3,
    OP_CLV = 3'd4,
    OP_CLD = 3'd5,
    OP_SED = 3'd6,
    OP_NOP = 3'd7
  } flag_op_t;

  // The six stored flags; B and the constant-1 bit never live in flops.
  typedef struct packed {
    logic n;
    logic v;
    logic d;
    logic i;
    logic z;
    logic c;
  } flags_t;

  function automatic flags_t byte_to_flags(input logic [7:0] b);
    flags_t f;
    f.n = b[FLAG_N];
    f.v = b[FLAG_V];
    f.d = b[FLAG_D];
    f.i = b[FLAG_I];
    f.z = b[FLAG_Z];
    f.c = b[FLAG_C];
    return f;
  endfunction

  function automatic logic [7:0] flags_to_byte(input flags_t f, input logic b_bit);
    return {f.n, f.v, 1'b1, b_bit, f.d, f.i, f.z, f.c};
  endfunction

endpackage

// File: rtl/cpu_status_reg.sv
// 6502 processor status register: captures ALU flags, executes flag
// instructions, BIT, PLP/RTI pulls and interrupt entry, and tracks the IRQ mask.
module cpu_status_reg
  import cpu_pkg::*;
#(
  parameter bit DECIMAL_SUPPORT = 1'b0,
  parameter bit IRQ_MASK_DELAY  = 1'b1
) (
  input  logic       clk,
  input  logic       reset_N,
  input  logic       negative_FLAG_IN,
  input  logic       zero_FLAG_IN,
  input  logic       carry_FLAG_IN,
  input  logic       overflow_FLAG_IN,
  input  logic       load_NZ_EN,
  input  logic       load_C_EN,
  input  logic       load_V_EN,
  input  logic       bit_EN,
  input  logic       flag_op_EN,
  input  logic [2:0] flag_op_SEL,
  input  logic       pull_EN,
  input  logic       rti_EN,
  input  logic       int_entry_EN,
  input  logic       push_B_IN,
  input  logic       instr_boundary_IN,
  input  logic [7:0] data_BUS_IN,
  output logic [7:0] status_REG_OUT,
  output logic [7:0] status_PUSH_OUT,
  output logic       carry_FLAG_OUT,
  output logic       irq_MASK_OUT,
  output logic       decimal_MODE_OUT
);

  flags_t   r_flags;
  logic     r_mask;
  flags_t   w_flags_next;
  logic     w_mask_next;
  flag_op_t w_op;

  assign w_op = flag_op_t'(flag_op_SEL);

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r_flags <= byte_to_flags(P_RESET);
      r_mask  <= 1'b1;
    end else begin
      r_flags <= w_flags_next;
      r_mask  <= w_mask_next;
    end
  end

  // Each flag resolves its own priority chain; a pull replaces the whole register.
  always_comb begin
    w_flags_next = r_flags;
    if (pull_EN) begin
      w_flags_next = byte_to_flags(data_BUS_IN);
    end else begin
      if (bit_EN) begin
        w_flags_next.n = data_BUS_IN[FLAG_N];
      end else if (load_NZ_EN) begin
        w_flags_next.n = negative_FLAG_IN;
      end

      if (flag_op_EN && w_op == OP_CLV) begin
        w_flags_next.v = 1'b0;
      end else if (bit_EN) begin
        w_flags_next.v = data_BUS_IN[FLAG_V];
      end else if (load_V_EN) begin
        w_flags_next.v = overflow_FLAG_IN;
      end

      if (bit_EN || load_NZ_EN) begin
        w_flags_next.z = zero_FLAG_IN;
      end

      if (flag_op_EN && w_op == OP_CLC) begin
        w_flags_next.c = 1'b0;
      end else if (flag_op_EN && w_op == OP_SEC) begin
        w_flags_next.c = 1'b1;
      end else if (load_C_EN) begin
        w_flags_next.c = carry_FLAG_IN;
      end

      if (int_entry_EN) begin
        w_flags_next.i = 1'b1;
      end else if (flag_op_EN && w_op == OP_CLI) begin
        w_flags_next.i = 1'b0;
      end else if (flag_op_EN && w_op == OP_SEI) begin
        w_flags_next.i = 1'b1;
      end

      if (flag_op_EN && w_op == OP_CLD) begin
        w_flags_next.d = 1'b0;
      end else if (flag_op_EN && w_op == OP_SED) begin
        w_flags_next.d = 1'b1;
      end
    end
  end

  // The boundary samples the registered I, so a CLI in the poll cycle is seen one instruction late.
  always_comb begin
    w_mask_next = r_mask;
    if (pull_EN && rti_EN) begin
      w_mask_next = data_BUS_IN[FLAG_I];
    end else if (int_entry_EN && !pull_EN) begin
      w_mask_next = 1'b1;
    end else if (instr_boundary_IN) begin
      w_mask_next = r_flags.i;
    end
  end

  assign status_REG_OUT   = flags_to_byte(r_flags, 1'b0);
  assign status_PUSH_OUT  = flags_to_byte(r_flags, push_B_IN);
  assign carry_FLAG_OUT   = r_flags.c;
  assign irq_MASK_OUT     = IRQ_MASK_DELAY ? r_mask : r_flags.i;
  assign decimal_MODE_OUT = DECIMAL_SUPPORT ? r_flags.d : 1'b0;

endmodule

// File: tb/tb_cpu_status_reg.sv
// Directed bench for cpu_status_reg: a default instance (delayed mask, no
// decimal) and a second one with decimal enabled and an immediate mask.
`timescale 1ns/1ps
module tb_cpu_status_reg;

  logic       clk = 1'b0;
  logic       reset_N;
  logic       negative_FLAG_IN, zero_FLAG_IN, carry_FLAG_IN, overflow_FLAG_IN;
  logic       load_NZ_EN, load_C_EN, load_V_EN, bit_EN, flag_op_EN;
  logic [2:0] flag_op_SEL;
  logic       pull_EN, rti_EN, int_entry_EN, push_B_IN, instr_boundary_IN;
  logic [7:0] data_BUS_IN;

  logic [7:0] statusA, pushA, statusB, pushB;
  logic       carryA, maskA, decA, carryB, maskB, decB;

  int numChecks = 0;
  int numErrors = 0;

  always #5 clk = ~clk;

  cpu_status_reg #(.DECIMAL_SUPPORT(1'b0), .IRQ_MASK_DELAY(1'b1)) dut (
    .clk(clk), .reset_N(reset_N),
    .negative_FLAG_IN(negative_FLAG_IN), .zero_FLAG_IN(zero_FLAG_IN),
    .carry_FLAG_IN(carry_FLAG_IN), .overflow_FLAG_IN(overflow_FLAG_IN),
    .load_NZ_EN(load_NZ_EN), .load_C_EN(load_C_EN), .load_V_EN(load_V_EN),
    .bit_EN(bit_EN), .flag_op_EN(flag_op_EN), .flag_op_SEL(flag_op_SEL),
    .pull_EN(pull_EN), .rti_EN(rti_EN), .int_entry_EN(int_entry_EN),
    .push_B_IN(push_B_IN), .instr_boundary_IN(instr_boundary_IN),
    .data_BUS_IN(data_BUS_IN),
    .status_REG_OUT(statusA), .status_PUSH_OUT(pushA),
    .carry_FLAG_OUT(carryA), .irq_MASK_OUT(maskA), .decimal_MODE_OUT(decA)
  );

  cpu_status_reg #(.DECIMAL_SUPPORT(1'b1), .IRQ_MASK_DELAY(1'b0)) dutAlt (
    .clk(clk), .reset_N(reset_N),
    .negative_FLAG_IN(negative_FLAG_IN), .zero_FLAG_IN(zero_FLAG_IN),
    .carry_FLAG_IN(carry_FLAG_IN), .overflow_FLAG_IN(overflow_FLAG_IN),
    .load_NZ_EN(load_NZ_EN), .load_C_EN(load_C_EN), .load_V_EN(load_V_EN),
    .bit_EN(bit_EN), .flag_op_EN(flag_op_EN), .flag_op_SEL(flag_op_SEL),
    .pull_EN(pull_EN), .rti_EN(rti_EN), .int_entry_EN(int_entry_EN),
    .push_B_IN(push_B_IN), .instr_boundary_IN(instr_boundary_IN),
    .data_BUS_IN(data_BUS_IN),
    .status_REG_OUT(statusB), .status_PUSH_OUT(pushB),
    .carry_FLAG_OUT(carryB), .irq_MASK_OUT(maskB), .decimal_MODE_OUT(decB)
  );

  task automatic clearEnables();
    load_NZ_EN = 0; load_C_EN = 0; load_V_EN = 0; bit_EN = 0;
    flag_op_EN = 0; flag_op_SEL = 3'd7; pull_EN = 0; rti_EN = 0;
    int_entry_EN = 0; instr_boundary_IN = 0;
  endtask

  // Advance one rising edge, settle, then drop all one-shot enables.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    clearEnables();
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    numChecks++;
    assert (observed === expected)
    else begin
      numErrors++;
      $error("[TB] FAIL %s: observed %02h expected %02h", tag, observed, expected);
    end
  endtask

  initial begin
    clearEnables();
    negative_FLAG_IN = 0; zero_FLAG_IN = 0; carry_FLAG_IN = 0; overflow_FLAG_IN = 0;
    push_B_IN = 0; data_BUS_IN = 8'h00;
    reset_N = 0;
    #12;
    checkOutput("reset_status", statusA, 8'h24);
    checkOutput("reset_mask", {7'd0, maskA}, 8'h01);
    checkOutput("reset_carry", {7'd0, carryA}, 8'h00);
    checkOutput("reset_dec", {7'd0, decA}, 8'h00);
    @(negedge clk);
    reset_N = 1;
    @(posedge clk); #1;
    checkOutput("release_status", statusA, 8'h24);

    // ALU capture of N,Z,C only; V must not follow
    negative_FLAG_IN = 1; zero_FLAG_IN = 0; carry_FLAG_IN = 1; overflow_FLAG_IN = 1;
    load_NZ_EN = 1; load_C_EN = 1;
    applyStimulus();
    checkOutput("alu_load", statusA, 8'hA5);
    checkOutput("alu_carry_out", {7'd0, carryA}, 8'h01);

    // SEC beats load_C
    carry_FLAG_IN = 0; load_C_EN = 1; flag_op_EN = 1; flag_op_SEL = 3'd1;
    applyStimulus();
    checkOutput("sec_over_load", statusA, 8'hA5);

    // CLC beats load_C
    carry_FLAG_IN = 1; load_C_EN = 1; flag_op_EN = 1; flag_op_SEL = 3'd0;
    applyStimulus();
    checkOutput("clc_over_load", statusA, 8'hA4);

    // BIT
    data_BUS_IN = 8'hC0; zero_FLAG_IN = 1; bit_EN = 1; load_NZ_EN = 1; negative_FLAG_IN = 0;
    applyStimulus();
    checkOutput("bit_op", statusA, 8'hE6);

    // CLV beats BIT on V
    data_BUS_IN = 8'h40; zero_FLAG_IN = 0; bit_EN = 1; flag_op_EN = 1; flag_op_SEL = 3'd4;
    applyStimulus();
    checkOutput("clv_over_bit", statusA, 8'h24);

    // PLP of FF: bits 5/4 discarded, mask waits for a boundary
    data_BUS_IN = 8'hFF; pull_EN = 1; push_B_IN = 1;
    applyStimulus();
    checkOutput("plp_status", statusA, 8'hEF);
    checkOutput("plp_push_b1", pushA, 8'hFF);
    push_B_IN = 0; #1;
    checkOutput("plp_push_b0", pushA, 8'hEF);
    checkOutput("plp_dec_tied", {7'd0, decA}, 8'h00);
    checkOutput("plp_dec_alt", {7'd0, decB}, 8'h01);

    // PLP of 00: delayed mask holds, immediate mask follows
    data_BUS_IN = 8'h00; pull_EN = 1;
    applyStimulus();
    checkOutput("plp0_status", statusA, 8'h20);
    checkOutput("plp0_mask_held", {7'd0, maskA}, 8'h01);
    checkOutput("plp0_mask_alt", {7'd0, maskB}, 8'h00);
    instr_boundary_IN = 1;
    applyStimulus();
    checkOutput("plp0_mask_boundary", {7'd0, maskA}, 8'h00);

    // SEI with boundary in the same cycle samples the old I
    flag_op_EN = 1; flag_op_SEL = 3'd3; instr_boundary_IN = 1;
    applyStimulus();
    checkOutput("sei_status", statusA, 8'h24);
    checkOutput("sei_mask_old", {7'd0, maskA}, 8'h00);
    checkOutput("sei_mask_alt", {7'd0, maskB}, 8'h01);
    instr_boundary_IN = 1;
    applyStimulus();
    checkOutput("sei_mask_next", {7'd0, maskA}, 8'h01);

    // CLI with boundary in the same cycle
    flag_op_EN = 1; flag_op_SEL = 3'd2; instr_boundary_IN = 1;
    applyStimulus();
    checkOutput("cli_status", statusA, 8'h20);
    checkOutput("cli_mask_held", {7'd0, maskA}, 8'h01);
    checkOutput("cli_mask_alt", {7'd0, maskB}, 8'h00);
    instr_boundary_IN = 1;
    applyStimulus();
    checkOutput("cli_mask_next", {7'd0, maskA}, 8'h00);

    // SEI then boundary, then RTI with I=0 clears mask at once
    flag_op_EN = 1; flag_op_SEL = 3'd3;
    applyStimulus();
    instr_boundary_IN = 1;
    applyStimulus();
    checkOutput("sei2_mask", {7'd0, maskA}, 8'h01);
    data_BUS_IN = 8'h81; pull_EN = 1; rti_EN = 1;
    applyStimulus();
    checkOutput("rti_status", statusA, 8'hA1);
    checkOutput("rti_mask", {7'd0, maskA}, 8'h00);

    // Interrupt entry beats CLI
    int_entry_EN = 1; flag_op_EN = 1; flag_op_SEL = 3'd2;
    applyStimulus();
    checkOutput("int_status", statusA, 8'hA5);
    checkOutput("int_mask", {7'd0, maskA}, 8'h01);

    // SED / CLD
    flag_op_EN = 1; flag_op_SEL = 3'd6;
    applyStimulus();
    checkOutput("sed_status", statusA, 8'hAD);
    checkOutput("sed_dec_tied", {7'd0, decA}, 8'h00);
    checkOutput("sed_dec_alt", {7'd0, decB}, 8'h01);
    flag_op_EN = 1; flag_op_SEL = 3'd5;
    applyStimulus();
    checkOutput("cld_status", statusA, 8'hA5);

    // No-op encoding and deasserted enable
    flag_op_EN = 1; flag_op_SEL = 3'd7;
    applyStimulus();
    checkOutput("nop_status", statusA, 8'hA5);
    flag_op_EN = 0; flag_op_SEL = 3'd0;
    applyStimulus();
    checkOutput("disabled_clc", statusA, 8'hA5);

    // Reset during a pending update
    negative_FLAG_IN = 0; zero_FLAG_IN = 1; load_NZ_EN = 1; load_V_EN = 1; overflow_FLAG_IN = 1;
    @(negedge clk);
    reset_N = 0;
    #1;
    checkOutput("midreset_async", statusA, 8'h24);
    @(posedge clk); #1;
    checkOutput("midreset_hold", statusA, 8'h24);
    checkOutput("midreset_mask", {7'd0, maskA}, 8'h01);
    clearEnables();
    @(negedge clk);
    reset_N = 1;
    @(posedge clk); #1;
    checkOutput("postreset_status", statusA, 8'h24);

    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule
